// File: rtl/sopc_boutons_pkg.sv
// Shared constants for the push-button controller: register map, debouncer state codes, CFG bit layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sopc_boutons_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_CFG  = 2'd3;

    // Debouncer state encoding
    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    // CFG register: edge polarity select (0 = press/falling, 1 = release/rising)
    localparam int POL_BIT = 0;

endpackage

// File: rtl/sopc_boutons_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
// Latency: readdata is registered, valid one cycle after address.
// Backpressure: none; no wait-request, every access completes in fixed time.
// Ports: address[1:0], chipselect, write_n, writedata[31:0] (master -> slave); readdata[31:0] (slave -> master).
interface sopc_boutons_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/sopc_boutons_debounce.sv
// One-bit button conditioner: 2-flop synchroniser, stability-window debouncer, direction-selected edge pulse.
// Latency: a clean pin change reaches stable at the end of cycle DEBOUNCE_CYCLES+1 after it appears.
// Backpressure: none; free-running per bit.
// Ports: clk, reset_n, pin (raw, async), polarity (1 = rising), stable (debounced level), edge_pulse (1-cycle).
module sopc_boutons_debounce
    import sopc_boutons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    input  logic polarity,
    output logic stable,
    output logic edge_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    // Stable level is about to flip on this edge; the pulse is combinational
    // so the EDGE register captures it on the same edge that stable updates.
    assign settle     = (state == ST_COUNTING) && (sync_b != stable) && (cnt == CNT_MAX);
    assign edge_pulse = settle && (sync_b == polarity);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            stable <= 1'b1;
            state  <= ST_STABLE;
            cnt    <= '0;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
            case (state)
                ST_STABLE: begin
                    // The first mismatching cycle already counts toward the window.
                    if (sync_b != stable) begin
                        state <= ST_COUNTING;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_COUNTING: begin
                    if (sync_b == stable) begin
                        // Glitch shorter than the window: discard.
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        stable <= sync_b;
                        state  <= ST_STABLE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sopc_boutons_ctrl.sv
// Push-button Avalon-MM slave: debounced levels, W1C edge capture, maskable level irq.
// Latency: readdata 1 cycle after address; irq 1 cycle after EDGE/MASK change.
// Backpressure: none; writes always accepted, reads fixed one wait state.
// Ports: clk, reset_n, bus (Avalon slave modport), in_port[WIDTH-1:0] (active-low pins), irq.
module sopc_boutons_ctrl
    import sopc_boutons_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sopc_boutons_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_r;
    logic             pol;
    logic             wr_en;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_next;
    logic             unused_wd;

    assign unused_wd = ^bus.writedata[31:WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_btn
        sopc_boutons_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk        (clk),
            .reset_n    (reset_n),
            .pin        (in_port[i]),
            .polarity   (pol),
            .stable     (level[i]),
            .edge_pulse (pulse[i])
        );
    end

    assign wr_en = bus.chipselect && !bus.write_n;
    assign clr   = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA: rd_next = 32'(level);
            ADDR_MASK: rd_next = 32'(mask);
            ADDR_EDGE: rd_next = 32'(edge_r);
            ADDR_CFG:  rd_next = 32'(pol);
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask         <= '0;
            edge_r       <= '0;
            pol          <= 1'b0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_en && bus.address == ADDR_MASK) mask <= bus.writedata[WIDTH-1:0];
            if (wr_en && bus.address == ADDR_CFG)  pol  <= bus.writedata[POL_BIT];
            // Set applied after clear so a same-edge event survives the W1C.
            edge_r       <= (edge_r & ~clr) | pulse;
            irq          <= |(edge_r & mask);
            bus.readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_sopc_boutons_ctrl.sv
// Bench for sopc_boutons_ctrl: directed test-plan steps then randomized traffic against a behavioural model.
// Latency: model predicts readdata/irq each cycle.
// Backpressure: n/a.
module tb_sopc_boutons_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] in_port;
    logic       irq;

    always #5 clk = ~clk;

    sopc_boutons_ctrl_if bus ();

    sopc_boutons_ctrl #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: a level flips once the delayed pin has disagreed
    // with it for DEB consecutive cycles.
    logic [1:0]  m_d1, m_d2, m_lvl, m_edge, m_mask;
    logic        m_pol, m_irq;
    logic [31:0] m_rd;
    int          m_run [2];

    task automatic model_reset();
        m_d1 = 2'b11; m_d2 = 2'b11; m_lvl = 2'b11;
        m_edge = 2'b00; m_mask = 2'b00; m_pol = 1'b0; m_irq = 1'b0;
        m_rd = 32'd0; m_run[0] = 0; m_run[1] = 0;
    endtask

    task automatic model_step();
        logic [1:0] set;
        logic [1:0] nxt;
        logic       wr;
        set = 2'b00;
        nxt = m_lvl;
        for (int i = 0; i < 2; i++) begin
            if (m_d2[i] != m_lvl[i]) m_run[i] = m_run[i] + 1;
            else                     m_run[i] = 0;
            if (m_run[i] == DEB) begin
                nxt[i]   = m_d2[i];
                m_run[i] = 0;
                // Press (new level 0) with pol 0, release (new level 1) with pol 1.
                if (m_d2[i] == m_pol) set[i] = 1'b1;
            end
        end
        case (bus.address)
            2'd0:    m_rd = {30'd0, m_lvl};
            2'd1:    m_rd = {30'd0, m_mask};
            2'd2:    m_rd = {30'd0, m_edge};
            default: m_rd = {31'd0, m_pol};
        endcase
        m_irq = |(m_edge & m_mask);
        wr = bus.chipselect && !bus.write_n;
        if (wr && bus.address == 2'd2) m_edge = m_edge & ~bus.writedata[1:0];
        m_edge = m_edge | set;
        if (wr && bus.address == 2'd1) m_mask = bus.writedata[1:0];
        if (wr && bus.address == 2'd3) m_pol  = bus.writedata[0];
        m_lvl = nxt;
        m_d2  = m_d1;
        m_d1  = in_port;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_readdata", bus.readdata, m_rd);
        chk("model_irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        in_port        = 2'b00;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        model_reset();

        // Reset state with buttons held pressed
        repeat (3) @(negedge clk);
        chk("rst_readdata", bus.readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        reset_n = 1'b1;
        tick();
        chk("data_after_rst", bus.readdata, 32'd3);
        repeat (12) tick();
        chk("data_pressed", bus.readdata, 32'd0);
        in_port = 2'b11;
        repeat (12) tick();
        bus.address = 2'd2;
        tick();
        chk("edge_both", bus.readdata, 32'd3);

        // Mask then W1C
        wr(2'd1, 32'd3);
        tick();
        chk("irq_mask_on", 32'(irq), 32'd1);
        wr(2'd2, 32'd1);
        tick();
        chk("w1c_edge", bus.readdata, 32'd2);
        chk("w1c_irq", 32'(irq), 32'd1);
        wr(2'd1, 32'd1);
        tick();
        chk("irq_masked", 32'(irq), 32'd0);
        wr(2'd2, 32'd2);

        // Clean press on bit0: EDGE sets on the 6th edge, irq one later
        in_port = 2'b10;
        repeat (6) tick();
        chk("press_irq_early", 32'(irq), 32'd0);
        tick();
        chk("press_irq", 32'(irq), 32'd1);
        bus.address = 2'd0;
        tick();
        chk("press_data", bus.readdata, 32'd2);

        // 3-cycle glitch on bit1 must be rejected
        in_port = 2'b00;
        repeat (3) tick();
        in_port = 2'b10;
        repeat (8) tick();
        chk("glitch_data", bus.readdata, 32'd2);
        bus.address = 2'd2;
        tick();
        chk("glitch_edge", bus.readdata, 32'd1);
        chk("glitch_irq", 32'(irq), 32'd1);

        // Release of bit0 with rising polarity collides with a W1C of bit0
        wr(2'd3, 32'd1);
        in_port = 2'b11;
        repeat (5) tick();
        wr(2'd2, 32'd1);
        tick();
        chk("simul_edge", bus.readdata, 32'd1);
        chk("simul_irq", 32'(irq), 32'd1);

        // Rising polarity: press ignored, release captured
        wr(2'd2, 32'd3);
        in_port = 2'b01;
        repeat (10) tick();
        chk("pol_press_edge", bus.readdata, 32'd0);
        in_port = 2'b11;
        repeat (10) tick();
        chk("pol_release_edge", bus.readdata, 32'd2);
        chk("pol_irq", 32'(irq), 32'd0);

        // Reset in the middle of a debounce window
        in_port = 2'b10;
        repeat (4) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_readdata", bus.readdata, 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        in_port = 2'b11;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) tick();
        chk("rst_mid_edge", bus.readdata, 32'd0);
        bus.address = 2'd0;
        tick();
        chk("rst_mid_data", bus.readdata, 32'd3);

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 9) == 0) in_port[b] = ~in_port[b];
            end
            bus.address    = 2'($urandom_range(0, 3));
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = ($urandom_range(0, 2) != 0);
            bus.writedata  = $urandom;
            tick();
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
